adder_pipe: RTL and testbench
=============================

ADDER_PIPE -- requirements
Module: adder_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, bits resolved per pipeline stage; WIDTH % CHUNK == 0, CHUNK in 1..8.
REQ-003 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port valid_i  input  1  operand beat valid.
REQ-006 SHALL have port ready_o  output  1  block accepts a beat this cycle.
REQ-007 SHALL have port a_i  input  WIDTH  operand A.
REQ-008 SHALL have port b_i  input  WIDTH  operand B.
REQ-009 SHALL have port carry_i  input  1  carry-in (add mode only).
REQ-010 SHALL have port sub_i  input  1  0 = A+B+carry_i, 1 = A-B.
REQ-011 SHALL have port valid_o  output  1  result beat valid.
REQ-012 SHALL have port ready_i  input  1  downstream accepts result.
REQ-013 SHALL have port sum_o  output  WIDTH  result.
REQ-014 SHALL have port carry_o  output  1  carry out of MSB (sub: 1 = no borrow).
REQ-015 SHALL have port overflow_o  output  1  two's-complement signed overflow.

Function
REQ-016 SHALL compute with NS = WIDTH/CHUNK stages; stage k resolves bits [k*CHUNK +: CHUNK] by carry-lookahead (per-bit G = a&b, P = a^b) using the registered carry of stage k-1.
REQ-017 SHALL in sub mode use B' = ~b_i and carry-in 1, ignoring carry_i; add mode uses B' = b_i, carry-in carry_i.
REQ-018 SHALL register inter-stage carry and skew unprocessed operand chunks and completed sum chunks so all bits of a beat emerge together.
REQ-019 SHALL have latency exactly NS cycles from accepted beat (valid_i & ready_o) to valid_o, absent stalls.
REQ-020 SHALL sustain one beat per cycle when ready_i held high.
REQ-021 SHALL use one global advance enable en = ready_i | ~valid_o; ready_o = en; no bubble collapse.
REQ-022 SHALL, when en = 0, hold every pipeline register, sum_o, carry_o, overflow_o, valid_o stable.
REQ-023 SHALL, on en = 1 with valid_i = 0, insert a bubble (stage valid 0) at stage 0.
REQ-024 SHALL compute overflow_o = carry into MSB XOR carry out of MSB.
REQ-025 SHALL wrap modulo 2^WIDTH; e.g. all-ones + 1 -> sum 0, carry_o 1.
REQ-026 SHALL keep beats strictly in order; no beat dropped or duplicated under any valid/ready pattern.
REQ-027 SHALL drive sum_o/carry_o/overflow_o as don't-care-free registered values: contents of last stage regardless of valid_o.

Reset
REQ-028 SHALL on rst_ni low asynchronously clear all stage valid bits, carries, skew registers; valid_o, sum_o, carry_o, overflow_o = 0.
REQ-029 SHALL on reset mid-operation discard all in-flight beats; ready_o = 1 in first cycle after release.

Structure
REQ-030 SHALL place default WIDTH/CHUNK constants and a stage-record typedef (valid, carry, sub) in shared package adder_pkg.
REQ-031 SHALL instantiate NS copies of one combinational sub-module cla_chunk (params CHUNK; in a, b, c; out sum, c_out, c_msb_in).

Verification (WIDTH=32, CHUNK=4, NS=8)
REQ-032 SHALL test: add 0x0000_0005 + 0x0000_0003, carry_i 0 -> after 8 cycles sum 0x0000_0008, carry 0, ovf 0.
REQ-033 SHALL test: add 0xFFFF_FFFF + 0x0000_0000, carry_i 1 -> sum 0x0000_0000, carry 1, ovf 0 (full ripple across all stages).
REQ-034 SHALL test: sub 0x8000_0000 - 0x0000_0001 -> sum 0x7FFF_FFFF, carry 1, ovf 1; sub 3 - 5 -> 0xFFFF_FFFE, carry 0, ovf 0.
REQ-035 SHALL test: 20 back-to-back random beats, ready_i toggled pseudo-randomly -> all results match model, in order, outputs stable while valid_o & ~ready_i.
REQ-036 SHALL test: rst_ni pulsed low with 5 beats in flight -> valid_o 0 immediately, no stale beat after release, next beat returns in 8 cycles.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants, stage record and skew-layout helpers for the pipelined adder.
package adder_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_CHUNK = 4;

    // Per-stage control record carried alongside each beat.
    typedef struct packed {
        logic valid;
        logic carry;
        logic sub;
    } stage_t;

    // Bit offset of stage k's completed-sum region in the flat sum skew bus.
    // Stage k holds (k+1)*chunk resolved bits.
    function automatic int unsigned sum_off(input int unsigned chunk, input int unsigned k);
        return (chunk * k * (k + 1)) / 2;
    endfunction

    // Bit offset of stage k's unprocessed-operand region in the flat operand skew bus.
    // Stage k holds width-(k+1)*chunk operand bits still waiting to be resolved.
    function automatic int unsigned op_off(input int unsigned width, input int unsigned chunk,
                                           input int unsigned k);
        return (k * width) - ((chunk * k * (k + 1)) / 2);
    endfunction

endpackage

// File: rtl/cla_chunk.sv
// Combinational carry-lookahead block resolving one CHUNK-wide slice.
module cla_chunk #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             c,
    output logic [CHUNK-1:0] sum,
    output logic             c_out,
    output logic             c_msb_in
);

    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;
    logic [CHUNK:0]   cy;

    assign g = a & b;
    assign p = a ^ b;

    // Flat lookahead: every carry is a sum of generate terms gated by propagate runs.
    always_comb begin
        logic term;
        logic run;
        cy   = '0;
        term = 1'b0;
        run  = 1'b0;
        cy[0] = c;
        for (int i = 0; i < int'(CHUNK); i++) begin
            term = g[i];
            run  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                term = term | (run & g[j]);
                run  = run & p[j];
            end
            cy[i+1] = term | (run & c);
        end
    end

    assign sum      = p ^ cy[CHUNK-1:0];
    assign c_out    = cy[CHUNK];
    assign c_msb_in = cy[CHUNK-1];

endmodule

// File: rtl/adder_pipe.sv
// Pipelined add/subtract: one CHUNK of bits resolved per stage, operands and
// partial sums skewed so every bit of a beat leaves the last stage together.
module adder_pipe
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CHUNK = DEF_CHUNK
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
    input  logic             sub_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             overflow_o
);

    localparam int unsigned NS  = WIDTH / CHUNK;
    // Operand skew holds the not-yet-resolved upper bits for stages 0..NS-2.
    localparam int unsigned OPW = (NS > 1) ? op_off(WIDTH, CHUNK, NS - 1) : 1;
    // Sum skew holds the growing resolved low bits for stages 0..NS-1.
    localparam int unsigned SMW = sum_off(CHUNK, NS);
    localparam int unsigned LAST_SOFF = sum_off(CHUNK, NS - 1);

    stage_t           st_q [NS];
    stage_t           st_d [NS];
    logic [OPW-1:0]   a_sk_q;
    logic [OPW-1:0]   a_sk_d;
    logic [OPW-1:0]   b_sk_q;
    logic [OPW-1:0]   b_sk_d;
    logic [SMW-1:0]   s_sk_q;
    logic [SMW-1:0]   s_sk_d;
    logic             ovf_q;
    logic             ovf_d;

    logic             en;
    logic [WIDTH-1:0] b_mod;
    logic             c0;

    // Single global advance: the pipe moves whenever the output slot is free or draining.
    assign en      = ready_i | ~valid_o;
    assign ready_o = en;

    // Subtract is A + ~B + 1; carry_i only participates in add mode.
    assign b_mod = sub_i ? ~b_i : b_i;
    assign c0    = sub_i ? 1'b1 : carry_i;

    // Per-stage lookahead slice plus skew routing.
    for (genvar k = 0; k < int'(NS); k++) begin : g_st
        localparam int unsigned RW   = WIDTH - ((k + 1) * CHUNK);
        localparam int unsigned SOFF = sum_off(CHUNK, k);

        logic [CHUNK-1:0] a_c;
        logic [CHUNK-1:0] b_c;
        logic [CHUNK-1:0] s_c;
        logic             c_in;
        logic             c_out;
        logic             c_msb;
        logic             v_in;
        logic             sub_in;

        if (k == 0) begin : g_head
            assign a_c    = a_i[CHUNK-1:0];
            assign b_c    = b_mod[CHUNK-1:0];
            assign c_in   = c0;
            assign v_in   = valid_i;
            assign sub_in = sub_i;
            assign s_sk_d[SOFF +: CHUNK] = s_c;
            if (NS > 1) begin : g_skew
                assign a_sk_d[op_off(WIDTH, CHUNK, 0) +: RW] = a_i[WIDTH-1:CHUNK];
                assign b_sk_d[op_off(WIDTH, CHUNK, 0) +: RW] = b_mod[WIDTH-1:CHUNK];
            end
        end else begin : g_body
            localparam int unsigned POFF  = op_off(WIDTH, CHUNK, k - 1);
            localparam int unsigned PSOFF = sum_off(CHUNK, k - 1);
            assign a_c    = a_sk_q[POFF +: CHUNK];
            assign b_c    = b_sk_q[POFF +: CHUNK];
            assign c_in   = st_q[k-1].carry;
            assign v_in   = st_q[k-1].valid;
            assign sub_in = st_q[k-1].sub;
            assign s_sk_d[SOFF +: ((k + 1) * CHUNK)] = {s_c, s_sk_q[PSOFF +: (k * CHUNK)]};
            if (k < int'(NS) - 1) begin : g_skew
                assign a_sk_d[op_off(WIDTH, CHUNK, k) +: RW] = a_sk_q[(POFF + CHUNK) +: RW];
                assign b_sk_d[op_off(WIDTH, CHUNK, k) +: RW] = b_sk_q[(POFF + CHUNK) +: RW];
            end
        end

        cla_chunk #(
            .CHUNK(CHUNK)
        ) u_cla (
            .a       (a_c),
            .b       (b_c),
            .c       (c_in),
            .sum     (s_c),
            .c_out   (c_out),
            .c_msb_in(c_msb)
        );

        assign st_d[k] = '{valid: v_in, carry: c_out, sub: sub_in};

        // Signed overflow only exists at the MSB slice.
        if (k == int'(NS) - 1) begin : g_tail
            assign ovf_d = c_out ^ c_msb;
        end
    end

    // Degenerate single-stage configuration has no operand skew.
    if (NS == 1) begin : g_no_skew
        assign a_sk_d = '0;
        assign b_sk_d = '0;
    end

    // Pipeline registers: all advance together on en, all clear on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < int'(NS); k++) begin
                st_q[k] <= '0;
            end
            a_sk_q <= '0;
            b_sk_q <= '0;
            s_sk_q <= '0;
            ovf_q  <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < int'(NS); k++) begin
                st_q[k] <= st_d[k];
            end
            a_sk_q <= a_sk_d;
            b_sk_q <= b_sk_d;
            s_sk_q <= s_sk_d;
            ovf_q  <= ovf_d;
        end
    end

    assign valid_o    = st_q[NS-1].valid;
    assign carry_o    = st_q[NS-1].carry;
    assign sum_o      = s_sk_q[LAST_SOFF +: WIDTH];
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_adder_pipe.sv
// Directed + randomized scoreboard bench for adder_pipe (WIDTH=32, CHUNK=4).
module tb_adder_pipe;

    localparam int unsigned W   = 32;
    localparam int          LAT = 8;

    typedef struct {
        logic [W-1:0] sum;
        logic         carry;
        logic         ovf;
        int           acc;
        bit           lat;
        string        tag;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_ni;
    logic         valid_i;
    logic         ready_o;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         carry_i;
    logic         sub_i;
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] sum_o;
    logic         carry_o;
    logic         overflow_o;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   rand_rdy = 1'b0;
    exp_t sb[$];

    bit           hold_pend = 1'b0;
    logic [W-1:0] h_sum;
    logic         h_carry;
    logic         h_ovf;
    exp_t         mon_e;

    adder_pipe #(
        .WIDTH(32),
        .CHUNK(4)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .a_i       (a_i),
        .b_i       (b_i),
        .carry_i   (carry_i),
        .sub_i     (sub_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .sum_o     (sum_o),
        .carry_o   (carry_o),
        .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Reference: widened arithmetic, overflow from operand/result sign rule.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, input logic s);
        exp_t         e;
        logic [W-1:0] bb;
        logic         cin;
        logic [W:0]   full;
        bb   = s ? ~b : b;
        cin  = s ? 1'b1 : c;
        full = {1'b0, a} + {1'b0, bb} + {32'd0, cin};
        e.sum   = full[W-1:0];
        e.carry = full[W];
        e.ovf   = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        e.acc   = 0;
        e.lat   = 1'b0;
        e.tag   = "";
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) ready_i = ($urandom_range(0, 3) != 0);
    endtask

    // Present one beat and hold it until the handshake completes.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic s, input bit lat, input string tag);
        exp_t e;
        bit   ok;
        ok      = 1'b0;
        valid_i = 1'b1;
        a_i     = a;
        b_i     = b;
        carry_i = c;
        sub_i   = s;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (ready_o) begin
                ok    = 1'b1;
                e     = model(a, b, c, s);
                e.acc = cyc;
                e.lat = lat;
                e.tag = tag;
                sb.push_back(e);
            end
            tick();
        end
        valid_i = 1'b0;
        checks++;
        assert (ok) else begin
            errors++;
            $error("FAIL %s_accept: observed no handshake in 100 cycles, required accept", tag);
        end
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 300 && sb.size() != 0; n++) tick();
        check({tag, "_drain"}, 32'(sb.size()), 32'd0);
    endtask

    // Output monitor: pops the scoreboard on each transfer, checks stall stability.
    always @(negedge clk) begin
        if (!rst_ni) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", 32'(valid_o), 32'd1);
                check("hold_sum", sum_o, h_sum);
                check("hold_carry", 32'(carry_o), 32'(h_carry));
                check("hold_ovf", 32'(overflow_o), 32'(h_ovf));
            end
            hold_pend = 1'b0;
            if (valid_o && ready_i) begin
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL extra_beat: observed result %h, required no beat", sum_o);
                end
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check({mon_e.tag, "_sum"}, sum_o, mon_e.sum);
                    check({mon_e.tag, "_carry"}, 32'(carry_o), 32'(mon_e.carry));
                    check({mon_e.tag, "_ovf"}, 32'(overflow_o), 32'(mon_e.ovf));
                    if (mon_e.lat) check({mon_e.tag, "_lat"}, 32'(cyc - mon_e.acc), 32'(LAT));
                end
            end else if (valid_o) begin
                hold_pend = 1'b1;
                h_sum     = sum_o;
                h_carry   = carry_o;
                h_ovf     = overflow_o;
            end
        end
    end

    initial begin
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        a_i     = '0;
        b_i     = '0;
        carry_i = 1'b0;
        sub_i   = 1'b0;
        ready_i = 1'b1;

        // Reset state
        repeat (3) tick();
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_sum", sum_o, 32'd0);
        check("rst_carry", 32'(carry_o), 32'd0);
        check("rst_ovf", 32'(overflow_o), 32'd0);
        rst_ni = 1'b1;
        tick();
        check("rst_ready", 32'(ready_o), 32'd1);

        // Directed arithmetic, free-flowing output
        send(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 1'b1, "add_5_3");
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1, "add_ripple");
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, "sub_min_1");
        send(32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1, 1'b1, "sub_3_5");
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, "add_pos_ovf");
        drain("directed");

        // Random back-to-back beats with pseudo-random backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b0, $sformatf("rnd%0d", i));
        end
        drain("random");
        rand_rdy = 1'b0;
        ready_i  = 1'b1;
        tick();

        // Reset with five beats in flight and the head beat stalled at the output
        for (int i = 0; i < 5; i++) begin
            send(32'h1000_0000 * (i + 1), 32'h0000_0011, 1'b0, 1'b0, 1'b0, $sformatf("flight%0d", i));
        end
        tick();
        tick();
        ready_i = 1'b0;
        tick();
        tick();
        check("pre_rst_valid", 32'(valid_o), 32'd1);
        rst_ni = 1'b0;
        sb.delete();
        #1;
        check("midrst_valid", 32'(valid_o), 32'd0);
        check("midrst_sum", sum_o, 32'd0);
        check("midrst_carry", 32'(carry_o), 32'd0);
        check("midrst_ready", 32'(ready_o), 32'd1);
        tick();
        tick();
        rst_ni  = 1'b1;
        ready_i = 1'b1;
        #1;
        check("post_rst_ready", 32'(ready_o), 32'd1);
        send(32'h0000_0100, 32'h0000_0023, 1'b1, 1'b0, 1'b1, "post_rst");
        drain("post_rst");
        repeat (LAT + 2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
